disp_scan_ctrl: RTL

- Sequences the 4-digit multiplexed seven-segment display of the watch.
- Generates the digit-select phase internally, 3→2→1→0, same order as the existing 2-bit scan phase.
- Decodes hex nibbles to segments and inserts dead-time blanking between digits.
- Applies brightness PWM and per-digit blink; accepts new display values through a load/ack handshake so the value shown in a frame never tears.

---
 rtl/disp_scan_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with dead-time blanking, PWM dimming,
// per-digit blink and a frame-aligned load/ack shadow update. Optional: LEADING_ZERO_BLANK_EN.
module disp_scan_ctrl #(
   parameter int SCAN_DIV     = 12500,
   parameter int BLANK_CYCLES = 500
) (
   input  logic        clk_27Mhz,
   input  logic        reset,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic        load,
   output logic        load_ack,
   input  logic [3:0]  blink_mask,
   input  logic        blink_phase,
   input  logic [2:0]  brightness,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  digit_sel,
   output logic        frame_start
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   logic [CW-1:0] slot_cnt_q, slot_cnt_d;
   logic [1:0]    digit_sel_q, digit_sel_d;
   logic [2:0]    pwm_cnt_q, pwm_cnt_d;
   logic [0:0]    state_q, state_d;
   logic          pending_q, pending_d;
   logic [15:0]   digits_sh_q;
   logic [3:0]    dp_sh_q, mask_sh_q;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic          ack_q, fs_q, fs_d;
   logic          slot_wrap, update, drive_on, lz_blank;
   logic [3:0]    nib;
   logic [3:0]    lz;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;  4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
         4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;  4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
         4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;  4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
      endcase
   endfunction

   always_comb begin
      slot_wrap   = (slot_cnt_q == SLOT_LAST);
      slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + CW'(1);
      digit_sel_d = slot_wrap ? digit_sel_q - 2'd1 : digit_sel_q;
      state_d     = (slot_cnt_d < BLANK_END) ? ST_BLANK : ST_DRIVE;
      pwm_cnt_d   = pwm_cnt_q + 3'd1;
      fs_d        = (slot_cnt_d == '0) && (digit_sel_d == 2'd3);
      // Shadow swaps only at the frame boundary so one frame never mixes old and new values
      update      = slot_wrap && (digit_sel_q == 2'd0) && pending_q;
      pending_d   = update ? 1'b0 : (pending_q | load);
   end

   always_comb begin
      nib   = digits_sh_q[{digit_sel_q, 2'b00} +: 4];
      lz[3] = (digits_sh_q[15:12] == 4'h0);
      lz[2] = lz[3] && (digits_sh_q[11:8] == 4'h0);
      lz[1] = lz[2] && (digits_sh_q[7:4] == 4'h0);
      lz[0] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      lz_blank = lz[digit_sel_q];
`else
      lz_blank = 1'b0;
`endif
      drive_on = (state_q == ST_DRIVE) && (pwm_cnt_q <= brightness)
                 && !(mask_sh_q[digit_sel_q] && !blink_phase);
      an_d  = drive_on ? ~(4'b0001 << digit_sel_q) : 4'hF;
      seg_d = (drive_on && !lz_blank) ? ~hex7(nib) : 7'h7F;
      dp_d  = drive_on ? ~dp_sh_q[digit_sel_q] : 1'b1;
   end

   always_ff @(posedge clk_27Mhz) begin
      if (reset) begin
         slot_cnt_q  <= '0;
         digit_sel_q <= 2'd3;
         pwm_cnt_q   <= 3'd0;
         state_q     <= ST_BLANK;
         pending_q   <= 1'b0;
         digits_sh_q <= 16'h0000;
         dp_sh_q     <= 4'h0;
         mask_sh_q   <= 4'h0;
         an_q        <= 4'hF;
         seg_q       <= 7'h7F;
         dp_q        <= 1'b1;
         ack_q       <= 1'b0;
         fs_q        <= 1'b0;
      end else begin
         slot_cnt_q  <= slot_cnt_d;
         digit_sel_q <= digit_sel_d;
         pwm_cnt_q   <= pwm_cnt_d;
         state_q     <= state_d;
         pending_q   <= pending_d;
         if (update) begin
            digits_sh_q <= digits_in;
            dp_sh_q     <= dp_in;
            mask_sh_q   <= blink_mask;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
         ack_q <= update;
         fs_q  <= fs_d;
      end
   end

   assign an          = an_q;
   assign seg         = seg_q;
   assign dp          = dp_q;
   assign load_ack    = ack_q;
   assign frame_start = fs_q;
   assign digit_sel   = digit_sel_q;

endmodule
